// File: rtl/gcd_result_checker.sv
// gcd_result_checker
//   Snoops CPU data-memory word writes into a window of NUM_RESULTS result
//   slots starting at RESULT_BASE, then compares the captured values against
//   exp_vec once every slot has been written, or gives up after
//   TIMEOUT_CYCLES cycles in RUN.
//
//   State table
//   state | meaning
//   IDLE  | waiting for start after reset, all outputs cleared
//   RUN   | capturing result writes, counting cycles, watching for timeout
//   CHECK | all slots written; compare captures against exp_vec (one cycle)
//   DONE  | verdict held on outputs until start or reset
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   start           single-cycle pulse that arms monitoring (IDLE/DONE only)
//   d_mem_addr      snooped data-memory byte address
//   d_mem_wdata     snooped data-memory write data
//   d_mem_wen       snooped byte write enables
//   exp_vec         expected values, slot i at [32i+31:32i]
//   result_vec      captured values, same packing as exp_vec
//   valid_mask      bit i set once slot i has been written
//   fail_mask       bit i set when slot i mismatched or was never written
//   done            check completed
//   pass            all slots written and matched
//   timeout         run ended by timeout
//   cycle_count     RUN cycles elapsed, saturating
module gcd_result_checker #(
  parameter logic [31:0] RESULT_BASE    = 32'h200,
  parameter int          NUM_RESULTS    = 5,
  parameter int          TIMEOUT_CYCLES = 3000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [31:0]               d_mem_addr,
  input  logic [31:0]               d_mem_wdata,
  input  logic [3:0]                d_mem_wen,
  input  logic [NUM_RESULTS*32-1:0] exp_vec,
  output logic [NUM_RESULTS*32-1:0] result_vec,
  output logic [NUM_RESULTS-1:0]    valid_mask,
  output logic [NUM_RESULTS-1:0]    fail_mask,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout,
  output logic [15:0]               cycle_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] CYCLE_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                    state, state_nx;
  logic [NUM_RESULTS*32-1:0] result_nx;
  logic [NUM_RESULTS-1:0]    valid_nx;
  logic [NUM_RESULTS-1:0]    fail_nx;
  logic                      done_nx;
  logic                      pass_nx;
  logic                      timeout_nx;
  logic [15:0]               cycle_nx;

  logic                      word_wr;
  logic [NUM_RESULTS-1:0]    slot_hit;

  // A slot is hit only by a full, aligned word write to its exact address;
  // the exact-address match also covers the window bounds.
  always_comb begin
    word_wr = (state == RUN) && (d_mem_wen == 4'b1111) && (d_mem_addr[1:0] == 2'b00);
    for (int i = 0; i < NUM_RESULTS; i++) begin
      slot_hit[i] = word_wr && (d_mem_addr == RESULT_BASE + 32'(4 * i));
    end
  end

  always_comb begin
    state_nx   = state;
    result_nx  = result_vec;
    valid_nx   = valid_mask;
    fail_nx    = fail_mask;
    done_nx    = done;
    pass_nx    = pass;
    timeout_nx = timeout;
    cycle_nx   = cycle_count;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx   = RUN;
          result_nx  = '0;
          valid_nx   = '0;
          fail_nx    = '0;
          done_nx    = 1'b0;
          pass_nx    = 1'b0;
          timeout_nx = 1'b0;
          cycle_nx   = '0;
        end
      end

      RUN: begin
        if (cycle_count != 16'hFFFF) begin
          cycle_nx = cycle_count + 16'd1;
        end
        for (int i = 0; i < NUM_RESULTS; i++) begin
          if (slot_hit[i]) begin
            result_nx[32*i +: 32] = d_mem_wdata;
            valid_nx[i]           = 1'b1;
          end
        end
        // Completion is judged on the post-edge mask so that a final write
        // landing on the timeout edge still goes to CHECK.
        if (&valid_nx) begin
          state_nx = CHECK;
        end else if (cycle_count == CYCLE_LAST) begin
          state_nx   = DONE;
          done_nx    = 1'b1;
          timeout_nx = 1'b1;
          pass_nx    = 1'b0;
          fail_nx    = ~valid_nx;
        end
      end

      CHECK: begin
        for (int i = 0; i < NUM_RESULTS; i++) begin
          fail_nx[i] = (result_vec[32*i +: 32] != exp_vec[32*i +: 32]);
        end
        pass_nx  = (fail_nx == '0);
        done_nx  = 1'b1;
        state_nx = DONE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      result_vec  <= '0;
      valid_mask  <= '0;
      fail_mask   <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      state       <= state_nx;
      result_vec  <= result_nx;
      valid_mask  <= valid_nx;
      fail_mask   <= fail_nx;
      done        <= done_nx;
      pass        <= pass_nx;
      timeout     <= timeout_nx;
      cycle_count <= cycle_nx;
    end
  end

endmodule

// File: tb/tb_gcd_result_checker.sv
// Scoreboard bench for gcd_result_checker (NUM_RESULTS=5, TIMEOUT_CYCLES=20).
// Expected verdicts are pushed when a run is launched and popped when done.
module tb_gcd_result_checker;

  localparam int NR = 5;

  localparam logic [159:0] NOM    = {32'd1, 32'd15, 32'd7, 32'd6, 32'd4};
  localparam logic [159:0] MIS    = {32'd1, 32'd15, 32'd7, 32'd5, 32'd4};
  localparam logic [159:0] TO_RES = {32'd0, 32'd0, 32'd33, 32'd22, 32'd11};

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [31:0]       d_mem_addr;
  logic [31:0]       d_mem_wdata;
  logic [3:0]        d_mem_wen;
  logic [NR*32-1:0]  exp_vec;
  logic [NR*32-1:0]  result_vec;
  logic [NR-1:0]     valid_mask;
  logic [NR-1:0]     fail_mask;
  logic              done;
  logic              pass;
  logic              timeout;
  logic [15:0]       cycle_count;

  gcd_result_checker #(
    .RESULT_BASE    (32'h200),
    .NUM_RESULTS    (NR),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .d_mem_addr  (d_mem_addr),
    .d_mem_wdata (d_mem_wdata),
    .d_mem_wen   (d_mem_wen),
    .exp_vec     (exp_vec),
    .result_vec  (result_vec),
    .valid_mask  (valid_mask),
    .fail_mask   (fail_mask),
    .done        (done),
    .pass        (pass),
    .timeout     (timeout),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         pass_e;
    logic         timeout_e;
    logic [4:0]   fail_e;
    logic [4:0]   valid_e;
    logic [159:0] res_e;
    logic [15:0]  cc_e;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    d_mem_addr  = a;
    d_mem_wdata = d;
    d_mem_wen   = w;
    step();
    d_mem_wen   = 4'h0;
  endtask

  task automatic wr_slot(input int i, input logic [159:0] vals);
    wr(32'h200 + 32'(4 * i), vals[32*i +: 32], 4'hF);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_cc", 160'(cycle_count), 160'(0));
    chk("start_valid", 160'(valid_mask), 160'(0));
    chk("start_done", 160'(done), 160'(0));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_done"}, 160'(done), 160'(0));
    chk({tag, "_pass"}, 160'(pass), 160'(0));
    chk({tag, "_tmo"}, 160'(timeout), 160'(0));
    chk({tag, "_valid"}, 160'(valid_mask), 160'(0));
    chk({tag, "_fail"}, 160'(fail_mask), 160'(0));
    chk({tag, "_res"}, result_vec, 160'(0));
    chk({tag, "_cc"}, 160'(cycle_count), 160'(0));
  endtask

  task automatic sb_push(input logic p, input logic t, input logic [4:0] f,
                         input logic [4:0] v, input logic [159:0] r, input logic [15:0] c);
    exp_t e;
    e.pass_e    = p;
    e.timeout_e = t;
    e.fail_e    = f;
    e.valid_e   = v;
    e.res_e     = r;
    e.cc_e      = c;
    sb_q.push_back(e);
  endtask

  task automatic sb_compare(input string tag);
    exp_t e;
    e = sb_q.pop_front();
    chk({tag, "_pass"}, 160'(pass), 160'(e.pass_e));
    chk({tag, "_tmo"}, 160'(timeout), 160'(e.timeout_e));
    chk({tag, "_fail"}, 160'(fail_mask), 160'(e.fail_e));
    chk({tag, "_valid"}, 160'(valid_mask), 160'(e.valid_e));
    chk({tag, "_res"}, result_vec, e.res_e);
    chk({tag, "_cc"}, 160'(cycle_count), 160'(e.cc_e));
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (done) break;
      step();
    end
    chk({tag, "_done"}, 160'(done), 160'(1));
    sb_compare(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    d_mem_addr  = '0;
    d_mem_wdata = '0;
    d_mem_wen   = '0;
    exp_vec     = NOM;
    step();
    step();
    chk_zero("rst");
    rst_n = 1'b1;
    step();
    step();
    chk_zero("idle");

    // nominal: done two edges after the final write
    do_start();
    sb_push(1'b1, 1'b0, 5'b00000, 5'b11111, NOM, 16'd5);
    for (int i = 0; i < NR; i++) wr_slot(i, NOM);
    chk("nom_lat_k", 160'(done), 160'(0));
    step();
    chk("nom_lat_k1", 160'(done), 160'(1));
    sb_compare("nom");
    // exp_vec changes in DONE must not disturb the verdict
    exp_vec = ~NOM;
    step();
    step();
    chk("hold_pass", 160'(pass), 160'(1));
    chk("hold_fail", 160'(fail_mask), 160'(0));
    exp_vec = NOM;

    // mismatch on slot 1; a start pulse mid-run is ignored
    do_start();
    sb_push(1'b0, 1'b0, 5'b00010, 5'b11111, MIS, 16'd5);
    wr_slot(0, MIS);
    wr_slot(1, MIS);
    start = 1'b1;
    wr_slot(2, MIS);
    start = 1'b0;
    wr_slot(3, MIS);
    wr_slot(4, MIS);
    wait_done("mis");

    // timeout with slots 0..2 written
    do_start();
    sb_push(1'b0, 1'b1, 5'b11000, 5'b00111, TO_RES, 16'd20);
    for (int i = 0; i < 3; i++) wr_slot(i, TO_RES);
    wait_done("tmo");
    wr(32'h20C, 32'd77, 4'hF);
    chk("done_wr_valid", 160'(valid_mask), 160'(5'b00111));
    chk("done_wr_res", result_vec, TO_RES);

    // filtering: start-cycle write, partial, misaligned, out of window
    start       = 1'b1;
    d_mem_addr  = 32'h200;
    d_mem_wdata = 32'hDEAD;
    d_mem_wen   = 4'hF;
    step();
    start       = 1'b0;
    d_mem_wen   = 4'h0;
    wr(32'h200, 32'h1111, 4'b0011);
    wr(32'h202, 32'h2222, 4'hF);
    wr(32'h214, 32'h3333, 4'hF);
    wr(32'h1FC, 32'h4444, 4'hF);
    chk("flt_valid", 160'(valid_mask), 160'(0));
    chk("flt_res", result_vec, 160'(0));
    sb_push(1'b1, 1'b0, 5'b00000, 5'b11111, NOM, 16'd10);
    wr(32'h200, 32'd9, 4'hF);
    chk("flt_slot0_9", 160'(result_vec[31:0]), 160'(9));
    wr(32'h200, 32'd4, 4'hF);
    chk("flt_slot0_4", 160'(result_vec[31:0]), 160'(4));
    chk("flt_valid1", 160'(valid_mask), 160'(5'b00001));
    for (int i = 1; i < NR; i++) wr_slot(i, NOM);
    wait_done("flt");

    // race: final slot written on the timeout edge
    do_start();
    sb_push(1'b1, 1'b0, 5'b00000, 5'b11111, NOM, 16'd20);
    for (int i = 0; i < 4; i++) wr_slot(i, NOM);
    for (int i = 0; i < 15; i++) step();
    chk("race_cc19", 160'(cycle_count), 160'(19));
    wr_slot(4, NOM);
    chk("race_tmo", 160'(timeout), 160'(0));
    chk("race_check", 160'(done), 160'(0));
    wait_done("race");

    // reset mid-run after 3 captures
    do_start();
    for (int i = 0; i < 3; i++) wr_slot(i, NOM);
    rst_n = 1'b0;
    step();
    chk_zero("rstmid");
    rst_n = 1'b1;
    wr_slot(3, NOM);
    step();
    chk_zero("rstidle");
    do_start();
    sb_push(1'b1, 1'b0, 5'b00000, 5'b11111, NOM, 16'd5);
    for (int i = 0; i < NR; i++) wr_slot(i, NOM);
    wait_done("rerun");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
